write_pointer_manager: RTL

Write-side pointer and flag controller for the dual-clock FIFO, running entirely in the write clock domain. It is the producer-side counterpart to the read pointer manager. It accepts write requests, generates the RAM write enable and address, and maintains a wrap-bit binary write pointer plus its Gray-coded copy for export to the read domain. It also synchronizes the read domain's Gray pointer and from it derives full, almost-full, overflow and fill level.

---
 rtl/write_pointer_manager_pkg.sv | 20 ++
 rtl/write_pointer_manager_if.sv | 16 +
 rtl/sync_ff.sv | 17 +
 rtl/write_pointer_manager.sv | 46 ++++
 4 files changed

// File: rtl/write_pointer_manager_pkg.sv
// write_pointer_manager_pkg: Gray coding, depth and full-compare helpers shared by both FIFO pointer managers.
package write_pointer_manager_pkg;
   typedef logic [31:0] word_t;
   function automatic word_t bin2gray(word_t b);
      return b ^ (b >> 1);
   endfunction
   function automatic word_t gray2bin(word_t g);
      word_t b;
      b = g;
      for (int i = 1; i < 32; i++) b = b ^ (g >> i);
      return b;
   endfunction
   function automatic int depth(int pw);
      return 1 << pw;
   endfunction
   // Full when the two top Gray bits of an n-bit pointer differ and the rest match.
   function automatic logic full_cmp(word_t wg, word_t rg, int n);
      return wg == (rg ^ (word_t'(3) << (n - 2)));
   endfunction
endpackage

// File: rtl/write_pointer_manager_if.sv
// write_pointer_manager_if: producer/RAM/cross-domain signals of the write pointer manager.
interface write_pointer_manager_if #(parameter int PTR_WIDTH = 4);
   logic                 req_write;
   logic [PTR_WIDTH:0]   ptr_read_gray;
   logic [PTR_WIDTH-1:0] addr_write;
   logic                 en_write;
   logic [PTR_WIDTH:0]   ptr_write_gray;
   logic                 flag_full;
   logic                 flag_almost_full;
   logic                 flag_of;
   logic [PTR_WIDTH:0]   level_write;
   modport master (output req_write, ptr_read_gray,
                   input addr_write, en_write, ptr_write_gray, flag_full, flag_almost_full, flag_of, level_write);
   modport slave (input req_write, ptr_read_gray,
                  output addr_write, en_write, ptr_write_gray, flag_full, flag_almost_full, flag_of, level_write);
endinterface

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep reset-to-zero flop chain for bringing a Gray pointer into this clock domain.
module sync_ff #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
   always_comb stage_d = {stage_q[STAGES-2:0], d};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) stage_q <= '0;
      else stage_q <= stage_d;
   assign q = stage_q[STAGES-1];
endmodule

// File: rtl/write_pointer_manager.sv
// write_pointer_manager: write-domain pointer, Gray export and full/almost-full/overflow/level flags of the dual-clock FIFO.
module write_pointer_manager
   import write_pointer_manager_pkg::*;
#(
   parameter int PTR_WIDTH   = 4,
   parameter int AF_MARGIN   = 2,
   parameter int SYNC_STAGES = 2
) (
   input logic clk_write,
   input logic reset_n,
   write_pointer_manager_if.slave wif
);
   localparam int PW    = PTR_WIDTH + 1;
   localparam int DEPTH = depth(PTR_WIDTH);
   logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, rq_sync, rbin_sync, level;
   logic          of_q, of_d, full, en;
   sync_ff #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
      .clk(clk_write), .reset_n(reset_n), .d(wif.ptr_read_gray), .q(rq_sync)
   );
   always_comb begin
      full      = full_cmp(32'(wgray_q), 32'(rq_sync), PW);
      en        = wif.req_write && !full;
      wbin_d    = en ? wbin_q + PW'(1) : wbin_q;
      wgray_d   = PW'(bin2gray(32'(wbin_d)));
      of_d      = wif.req_write && full;
      rbin_sync = PW'(gray2bin(32'(rq_sync)));
      level     = wbin_q - rbin_sync;
   end
   always_ff @(posedge clk_write or negedge reset_n)
      if (!reset_n) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         of_q    <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         of_q    <= of_d;
      end
   assign wif.addr_write       = wbin_q[PTR_WIDTH-1:0];
   assign wif.en_write         = en;
   assign wif.ptr_write_gray   = wgray_q;
   assign wif.flag_full        = full;
   assign wif.flag_almost_full = level >= PW'(DEPTH - AF_MARGIN);
   assign wif.flag_of          = of_q;
   assign wif.level_write      = level;
endmodule
